// File: rtl/mips_decode_if.sv
// Bundle of fetch, register-file and ID/EX signals between the decoder and its neighbours.
// The slave modport is the decoder's view; master is the surrounding pipeline.
interface mips_decode_if;
  logic        pipeline_flush_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        instr_ready_o;
  logic [4:0]  rs_addr_o;
  logic [4:0]  rt_addr_o;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        ex_ready_i;
  logic        ex_valid_o;
  logic        r_type_o;
  logic [5:0]  opcode_o;
  logic [5:0]  funct_o;
  logic [31:0] alu_input1_o;
  logic [31:0] alu_input2_o;
  logic [31:0] store_data_o;
  logic [31:0] pc_o;
  logic [4:0]  dest_reg_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        illegal_o;
  logic [15:0] stall_count_o;

  modport master (
    output pipeline_flush_i, instr_valid_i, instr_i, pc_i, rs_data_i, rt_data_i, ex_ready_i,
    input  instr_ready_o, rs_addr_o, rt_addr_o, ex_valid_o, r_type_o, opcode_o, funct_o,
           alu_input1_o, alu_input2_o, store_data_o, pc_o, dest_reg_o,
           reg_write_o, mem_read_o, mem_write_o, illegal_o, stall_count_o
  );

  modport slave (
    input  pipeline_flush_i, instr_valid_i, instr_i, pc_i, rs_data_i, rt_data_i, ex_ready_i,
    output instr_ready_o, rs_addr_o, rt_addr_o, ex_valid_o, r_type_o, opcode_o, funct_o,
           alu_input1_o, alu_input2_o, store_data_o, pc_o, dest_reg_o,
           reg_write_o, mem_read_o, mem_write_o, illegal_o, stall_count_o
  );
endinterface

// File: rtl/mips_decode.sv
// MIPS-I instruction decode stage: operand selection, control decode, load-use stall
// detection and a single ID/EX register with valid/ready handshaking on both sides.
module mips_decode (
  input  logic         clk,
  input  logic         rst_n,
  mips_decode_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                         OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LW   = 6'h23,
                         OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [5:0]         w_op, w_fn;
  logic [4:0]         w_rs, w_rt, w_rd, w_shamt;
  logic signed [15:0] w_imm_s;
  logic signed [31:0] w_sext;
  logic [31:0]        w_zext;
  logic [31:0]        w_in1, w_in2;
  logic [4:0]         w_dest;
  logic               w_wr, w_mrd, w_mwr, w_ill, w_reads_rt;
  logic               w_advance, w_hazard;

  logic        r_ex_valid_p1, r_reg_write_p1, r_mem_read_p1, r_mem_write_p1, r_illegal_p1;
  logic        r_rtype_p1;
  logic [5:0]  r_opcode_p1, r_funct_p1;
  logic [31:0] r_in1_p1, r_in2_p1, r_store_p1, r_pc_p1;
  logic [4:0]  r_dest_p1;
  logic [15:0] r_stall_cnt;

  assign w_op    = bus.instr_i[31:26];
  assign w_rs    = bus.instr_i[25:21];
  assign w_rt    = bus.instr_i[20:16];
  assign w_rd    = bus.instr_i[15:11];
  assign w_shamt = bus.instr_i[10:6];
  assign w_fn    = bus.instr_i[5:0];
  assign w_imm_s = bus.instr_i[15:0];
  assign w_sext  = 32'(w_imm_s);
  assign w_zext  = {16'b0, bus.instr_i[15:0]};

  always_comb begin
    w_in1      = bus.rs_data_i;
    w_in2      = bus.rt_data_i;
    w_dest     = w_rt;
    w_wr       = 1'b0;
    w_mrd      = 1'b0;
    w_mwr      = 1'b0;
    w_ill      = 1'b0;
    w_reads_rt = 1'b0;
    if (w_op == OP_RTYPE) begin
      w_dest = w_rd;
      case (w_fn)
        FN_SLL, FN_SRL, FN_SRA: begin
          w_in1 = bus.rt_data_i; w_in2 = {27'b0, w_shamt}; w_wr = 1'b1; w_reads_rt = 1'b1;
        end
        FN_SLLV, FN_SRLV, FN_SRAV: begin
          w_in1 = bus.rt_data_i; w_in2 = bus.rs_data_i; w_wr = 1'b1; w_reads_rt = 1'b1;
        end
        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
          w_wr = 1'b1; w_reads_rt = 1'b1;
        end
        FN_JR:   ;
        default: w_ill = 1'b1;
      endcase
    end else begin
      case (w_op)
        OP_ADDI, OP_ADDIU:       begin w_in2 = w_sext; w_wr = 1'b1; end
        OP_LW:                   begin w_in2 = w_sext; w_wr = 1'b1; w_mrd = 1'b1; end
        OP_SW:                   begin w_in2 = w_sext; w_mwr = 1'b1; w_reads_rt = 1'b1; end
        OP_ANDI, OP_ORI, OP_XORI: begin w_in2 = w_zext; w_wr = 1'b1; end
        OP_BEQ, OP_BNE:          w_reads_rt = 1'b1;
        default:                 w_ill = 1'b1;
      endcase
    end
    if (w_dest == 5'd0) w_wr = 1'b0;
  end

  // Only a load sitting in EX can create a hazard; everything else is forwarded downstream.
  assign w_advance = bus.ex_ready_i | ~r_ex_valid_p1;
  assign w_hazard  = bus.instr_valid_i & r_ex_valid_p1 & r_mem_read_p1 & (r_dest_p1 != 5'd0) &
                     ((r_dest_p1 == w_rs) | ((r_dest_p1 == w_rt) & w_reads_rt));

  assign bus.rs_addr_o     = w_rs;
  assign bus.rt_addr_o     = w_rt;
  assign bus.instr_ready_o = rst_n & (bus.pipeline_flush_i | (w_advance & ~w_hazard));

  // ID/EX register (p0 decode -> p1 execute)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid_p1  <= 1'b0;
      r_reg_write_p1 <= 1'b0;
      r_mem_read_p1  <= 1'b0;
      r_mem_write_p1 <= 1'b0;
      r_illegal_p1   <= 1'b0;
      r_rtype_p1     <= 1'b0;
      r_opcode_p1    <= '0;
      r_funct_p1     <= '0;
      r_in1_p1       <= '0;
      r_in2_p1       <= '0;
      r_store_p1     <= '0;
      r_pc_p1        <= '0;
      r_dest_p1      <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (bus.pipeline_flush_i || (w_advance && w_hazard)) begin
        r_ex_valid_p1  <= 1'b0;
        r_reg_write_p1 <= 1'b0;
        r_mem_read_p1  <= 1'b0;
        r_mem_write_p1 <= 1'b0;
        r_illegal_p1   <= 1'b0;
      end else if (w_advance) begin
        r_ex_valid_p1  <= bus.instr_valid_i;
        r_reg_write_p1 <= bus.instr_valid_i & w_wr & ~w_ill;
        r_mem_read_p1  <= bus.instr_valid_i & w_mrd & ~w_ill;
        r_mem_write_p1 <= bus.instr_valid_i & w_mwr & ~w_ill;
        r_illegal_p1   <= bus.instr_valid_i & w_ill;
        r_rtype_p1     <= (w_op == OP_RTYPE);
        r_opcode_p1    <= w_op;
        r_funct_p1     <= w_fn;
        r_in1_p1       <= w_in1;
        r_in2_p1       <= w_in2;
        r_store_p1     <= bus.rt_data_i;
        r_pc_p1        <= bus.pc_i;
        r_dest_p1      <= w_dest;
      end
      if (w_hazard) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.ex_valid_o    = r_ex_valid_p1;
  assign bus.reg_write_o   = r_reg_write_p1;
  assign bus.mem_read_o    = r_mem_read_p1;
  assign bus.mem_write_o   = r_mem_write_p1;
  assign bus.illegal_o     = r_illegal_p1;
  assign bus.r_type_o      = r_rtype_p1;
  assign bus.opcode_o      = r_opcode_p1;
  assign bus.funct_o       = r_funct_p1;
  assign bus.alu_input1_o  = r_in1_p1;
  assign bus.alu_input2_o  = r_in2_p1;
  assign bus.store_data_o  = r_store_p1;
  assign bus.pc_o          = r_pc_p1;
  assign bus.dest_reg_o    = r_dest_p1;
  assign bus.stall_count_o = r_stall_cnt;
endmodule

// File: tb/tb_mips_decode.sv
// Directed bench for mips_decode: a decode vector table plus hand sequences for
// load-use stall, EX back-pressure, flush and reset corner cases.
module tb_mips_decode;
  logic clk = 1'b0;
  logic rst_n;
  mips_decode_if bus();

  mips_decode dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr, rs_d, rt_d;
    logic [31:0] in1, in2;
    logic [4:0]  dest;
    logic        rw, mr, mw, ill, rtype, chkdata;
  } vec_t;

  int     n_total = 0;
  int     n_pass  = 0;
  int     exp_stall = 0;
  vec_t   vt[13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
    bus.instr_i       = ins;
    bus.rs_data_i     = rsd;
    bus.rt_data_i     = rtd;
    bus.instr_valid_i = 1'b1;
  endtask

  localparam logic [31:0] I_LW5  = 32'h8C25FFFC;  // LW $5,-4($1)
  localparam logic [31:0] I_ADD6 = 32'h00A13020;  // ADD $6,$5,$1
  localparam logic [31:0] I_ADDI = 32'h2022FFFF;  // ADDI $2,$1,-1
  localparam logic [31:0] I_ORI  = 32'h356A8001;  // ORI $10,$11,0x8001

  initial begin
    vt[0]  = '{"addi_neg", 32'h2022FFFF, 32'h5,    32'h1234,     32'h5,        32'hFFFFFFFF, 5'd2,  1,0,0,0,0,1};
    vt[1]  = '{"sra",      32'h000419C3, 32'hDEAD, 32'h80000000, 32'h80000000, 32'h7,        5'd3,  1,0,0,0,1,1};
    vt[2]  = '{"add",      32'h00A13020, 32'h11,   32'h22,       32'h11,       32'h22,       5'd6,  1,0,0,0,1,1};
    vt[3]  = '{"sllv",     32'h01283804, 32'h3,    32'hF0,       32'hF0,       32'h3,        5'd7,  1,0,0,0,1,1};
    vt[4]  = '{"ori_zext", 32'h356A8001, 32'h100,  32'h0,        32'h100,      32'h8001,     5'd10, 1,0,0,0,0,1};
    vt[5]  = '{"lw",       32'h8C25FFFC, 32'h1000, 32'h77,       32'h1000,     32'hFFFFFFFC, 5'd5,  1,1,0,0,0,1};
    vt[6]  = '{"sw_r0",    32'hAC600008, 32'h200,  32'h0,        32'h200,      32'h8,        5'd0,  0,0,1,0,0,1};
    vt[7]  = '{"beq",      32'h10220010, 32'h7,    32'h9,        32'h7,        32'h9,        5'd2,  0,0,0,0,0,1};
    vt[8]  = '{"op3f",     32'hFC030000, 32'h1,    32'h2,        32'h0,        32'h0,        5'd3,  0,0,0,1,0,0};
    vt[9]  = '{"addi_r0",  32'h20200005, 32'h9,    32'h0,        32'h9,        32'h5,        5'd0,  0,0,0,0,0,1};
    vt[10] = '{"bad_fn",   32'h00221801, 32'h1,    32'h2,        32'h0,        32'h0,        5'd3,  0,0,0,1,1,0};
    vt[11] = '{"jr",       32'h03E00008, 32'h40,   32'h0,        32'h40,       32'h0,        5'd0,  0,0,0,0,1,1};
    vt[12] = '{"xori",     32'h3884FFFF, 32'hA5,   32'h3,        32'hA5,       32'h0000FFFF, 5'd4,  1,0,0,0,0,1};

    rst_n = 1'b0;
    bus.pipeline_flush_i = 1'b0;
    bus.instr_valid_i    = 1'b0;
    bus.instr_i          = '0;
    bus.pc_i             = '0;
    bus.rs_data_i        = '0;
    bus.rt_data_i        = '0;
    bus.ex_ready_i       = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(bus.instr_ready_o), 0);
    chk("rst_valid", 32'(bus.ex_valid_o), 0);
    chk("rst_stall", 32'(bus.stall_count_o), 0);
    chk("rst_in1",   bus.alu_input1_o, 0);
    chk("rst_rw",    32'(bus.reg_write_o), 0);
    rst_n = 1'b1;
    #1 chk("idle_ready", 32'(bus.instr_ready_o), 1);

    // Load-use stall: LW $5 then ADD $6,$5,$1
    tick();
    present(I_LW5, 32'h1000, 32'h0);
    tick();
    chk("lu_lw_mr", 32'(bus.mem_read_o), 1);
    present(I_ADD6, 32'h11, 32'h22);
    #1 chk("lu_ready0", 32'(bus.instr_ready_o), 0);
    tick();
    exp_stall++;
    chk("lu_bubble", 32'(bus.ex_valid_o), 0);
    chk("lu_bub_mr", 32'(bus.mem_read_o), 0);
    chk("lu_stall",  32'(bus.stall_count_o), 32'(exp_stall));
    #1 chk("lu_ready1", 32'(bus.instr_ready_o), 1);
    tick();
    chk("lu_add_v",   32'(bus.ex_valid_o), 1);
    chk("lu_add_dst", 32'(bus.dest_reg_o), 6);
    chk("lu_add_in1", bus.alu_input1_o, 32'h11);
    chk("lu_add_rw",  32'(bus.reg_write_o), 1);
    bus.instr_valid_i = 1'b0;
    tick();
    chk("lu_drain", 32'(bus.ex_valid_o), 0);

    // Decode table, one idle cycle between entries so no hazards arise
    for (int i = 0; i < 13; i++) begin
      present(vt[i].instr, vt[i].rs_d, vt[i].rt_d);
      bus.pc_i = 32'h0040_0000 + 32'(i * 4);
      #1;
      chk({vt[i].name, "_rsaddr"}, 32'(bus.rs_addr_o), 32'(vt[i].instr[25:21]));
      chk({vt[i].name, "_rtaddr"}, 32'(bus.rt_addr_o), 32'(vt[i].instr[20:16]));
      tick();
      chk({vt[i].name, "_valid"}, 32'(bus.ex_valid_o), 1);
      if (vt[i].chkdata) begin
        chk({vt[i].name, "_in1"}, bus.alu_input1_o, vt[i].in1);
        chk({vt[i].name, "_in2"}, bus.alu_input2_o, vt[i].in2);
      end
      chk({vt[i].name, "_dest"},  32'(bus.dest_reg_o), 32'(vt[i].dest));
      chk({vt[i].name, "_store"}, bus.store_data_o, vt[i].rt_d);
      chk({vt[i].name, "_pc"},    bus.pc_o, 32'h0040_0000 + 32'(i * 4));
      chk({vt[i].name, "_rw"},    32'(bus.reg_write_o), 32'(vt[i].rw));
      chk({vt[i].name, "_mr"},    32'(bus.mem_read_o), 32'(vt[i].mr));
      chk({vt[i].name, "_mw"},    32'(bus.mem_write_o), 32'(vt[i].mw));
      chk({vt[i].name, "_ill"},   32'(bus.illegal_o), 32'(vt[i].ill));
      chk({vt[i].name, "_rtype"}, 32'(bus.r_type_o), 32'(vt[i].rtype));
      chk({vt[i].name, "_op"},    32'(bus.opcode_o), 32'(vt[i].instr[31:26]));
      chk({vt[i].name, "_fn"},    32'(bus.funct_o), 32'(vt[i].instr[5:0]));
      bus.instr_valid_i = 1'b0;
      tick();
    end
    chk("tbl_stall", 32'(bus.stall_count_o), 32'(exp_stall));

    // EX back-pressure for 3 cycles
    present(I_ADDI, 32'h5, 32'h0);
    tick();
    bus.ex_ready_i = 1'b0;
    present(I_ORI, 32'h100, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold_ready", 32'(bus.instr_ready_o), 0);
      tick();
      chk("hold_valid", 32'(bus.ex_valid_o), 1);
      chk("hold_in1",   bus.alu_input1_o, 32'h5);
      chk("hold_dest",  32'(bus.dest_reg_o), 2);
    end
    bus.ex_ready_i = 1'b1;
    #1 chk("resume_ready", 32'(bus.instr_ready_o), 1);
    tick();
    chk("resume_dest", 32'(bus.dest_reg_o), 10);
    chk("resume_in1",  bus.alu_input1_o, 32'h100);
    bus.instr_valid_i = 1'b0;
    tick();

    // Flush during load-use stall
    present(I_LW5, 32'h1000, 32'h0);
    tick();
    present(I_ADD6, 32'h11, 32'h22);
    bus.pipeline_flush_i = 1'b1;
    #1 chk("fl_ready", 32'(bus.instr_ready_o), 1);
    tick();
    exp_stall++;
    chk("fl_valid", 32'(bus.ex_valid_o), 0);
    chk("fl_mr",    32'(bus.mem_read_o), 0);
    chk("fl_stall", 32'(bus.stall_count_o), 32'(exp_stall));
    bus.pipeline_flush_i = 1'b0;
    tick();
    chk("fl_next_v",   32'(bus.ex_valid_o), 1);
    chk("fl_next_dst", 32'(bus.dest_reg_o), 6);
    chk("fl_stall2",   32'(bus.stall_count_o), 32'(exp_stall));

    // Flush overrides EX back-pressure
    present(I_ADDI, 32'h5, 32'h0);
    tick();
    bus.ex_ready_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.pipeline_flush_i = 1'b1;
    tick();
    chk("flhold_valid", 32'(bus.ex_valid_o), 0);
    chk("flhold_rw",    32'(bus.reg_write_o), 0);
    bus.pipeline_flush_i = 1'b0;
    bus.ex_ready_i = 1'b1;
    tick();

    // Reset mid-stall
    present(I_LW5, 32'h1000, 32'h0);
    tick();
    present(I_ADD6, 32'h11, 32'h22);
    #1 chk("rs_stall_ready", 32'(bus.instr_ready_o), 0);
    rst_n = 1'b0;
    tick();
    chk("rs_valid", 32'(bus.ex_valid_o), 0);
    chk("rs_mr",    32'(bus.mem_read_o), 0);
    chk("rs_stall", 32'(bus.stall_count_o), 0);
    chk("rs_ready", 32'(bus.instr_ready_o), 0);
    rst_n = 1'b1;
    bus.instr_valid_i = 1'b0;
    tick();
    chk("rs_after", 32'(bus.ex_valid_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
